calc_result_display: RTL

//  Downstream stage of the 4-bit calculator. Consumes its registered 8-bit result.

---
 rtl/calc_result_display.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/calc_result_display.sv
`default_nettype none
// ============================================================================
// Module      : calc_result_display
// Description : Converts the 8-bit calculator result to three BCD digits with a
//               sequential shift-add-3 engine and scans them onto a
//               multiplexed 3-digit seven-segment display.
//               Optional build macro: LEADING_ZERO_BLANK_EN (blank leading zeros).
// Revision    : 1.0 - initial release
// ============================================================================
module calc_result_display #(
    parameter int SCAN_DIV = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  result,
    output logic [11:0] bcd,
    output logic        busy,
    output logic [6:0]  seg,
    output logic [2:0]  an
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int                 c_cnt_w     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [c_cnt_w-1:0] c_scan_last = c_cnt_w'(SCAN_DIV - 1);
    localparam logic [2:0]         c_last_shift = 3'd7;

    state_t             r_state;
    logic [19:0]        r_sh;
    logic [7:0]         r_last_val;
    logic [2:0]         r_cnt;
    logic [11:0]        r_bcd;
    logic               r_busy;

    logic [c_cnt_w-1:0] r_scan_cnt;
    logic [1:0]         r_digit;
    logic [6:0]         r_seg;
    logic [2:0]         r_an;

    logic [11:0]        w_adj;
    logic [19:0]        w_sh_next;
    logic [3:0]         w_nibble;
    logic               w_blank;
    logic [6:0]         w_seg;
    logic [2:0]         w_an;

    // Add-3 correction looks at the pre-shift nibble of each BCD digit.
    for (genvar i = 0; i < 3; i++) begin : g_nib
        assign w_adj[i*4 +: 4] = (r_sh[8 + i*4 +: 4] >= 4'd5) ?
                                 (r_sh[8 + i*4 +: 4] + 4'd3) :
                                  r_sh[8 + i*4 +: 4];
    end

    assign w_sh_next = {w_adj, r_sh[7:0]} << 1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_sh       <= 20'h00000;
            r_last_val <= 8'h00;
            r_cnt      <= 3'd0;
            r_bcd      <= 12'h000;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (result != r_last_val) begin
                        r_sh       <= {12'h000, result};
                        r_last_val <= result;
                        r_cnt      <= 3'd0;
                        r_busy     <= 1'b1;
                        r_state    <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    r_sh  <= w_sh_next;
                    r_cnt <= r_cnt + 3'd1;
                    if (r_cnt == c_last_shift) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_bcd   <= r_sh[19:8];
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        w_nibble = 4'h0;
        w_an     = 3'b000;
        w_blank  = 1'b0;
        case (r_digit)
            2'd0: begin
                w_nibble = r_bcd[3:0];
                w_an     = 3'b001;
            end
            2'd1: begin
                w_nibble = r_bcd[7:4];
                w_an     = 3'b010;
`ifdef LEADING_ZERO_BLANK_EN
                w_blank  = (r_bcd[11:4] == 8'h00);
`endif
            end
            2'd2: begin
                w_nibble = r_bcd[11:8];
                w_an     = 3'b100;
`ifdef LEADING_ZERO_BLANK_EN
                w_blank  = (r_bcd[11:8] == 4'h0);
`endif
            end
            default: begin
                w_nibble = 4'h0;
                w_an     = 3'b000;
            end
        endcase
    end

    always_comb begin
        w_seg = 7'h00;
        if (!w_blank) begin
            case (w_nibble)
                4'd0:    w_seg = 7'h3F;
                4'd1:    w_seg = 7'h06;
                4'd2:    w_seg = 7'h5B;
                4'd3:    w_seg = 7'h4F;
                4'd4:    w_seg = 7'h66;
                4'd5:    w_seg = 7'h6D;
                4'd6:    w_seg = 7'h7D;
                4'd7:    w_seg = 7'h07;
                4'd8:    w_seg = 7'h7F;
                4'd9:    w_seg = 7'h6F;
                default: w_seg = 7'h00;
            endcase
        end
    end

    // Free-running scan; bcd updates appear on whichever digit is shown next.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_scan_cnt <= '0;
            r_digit    <= 2'd0;
            r_seg      <= 7'h00;
            r_an       <= 3'b000;
        end else begin
            if (r_scan_cnt == c_scan_last) begin
                r_scan_cnt <= '0;
                r_digit    <= (r_digit == 2'd2) ? 2'd0 : (r_digit + 2'd1);
            end else begin
                r_scan_cnt <= r_scan_cnt + 1'b1;
            end
            r_seg <= w_seg;
            r_an  <= w_an;
        end
    end

    assign bcd  = r_bcd;
    assign busy = r_busy;
    assign seg  = r_seg;
    assign an   = r_an;

endmodule
`default_nettype wire
